rvs_ooo: RTL and testbench

Parametrised out-of-order reservation station. It accepts decoded micro-ops from dispatch and captures operand results from N_CDB common data buses. It issues the oldest entry whose operands are both ready, rather than strictly in order. It sits between the decoder/rename stage and one execution unit (ALU, MDU or LSU), and each entry carries a fixed producer tag.

---
 rtl/rvs_ooo_if.sv | 63 ++++++
 rtl/rvs_ooo.sv | 183 ++++++++++++++++++
 tb/tb_rvs_ooo.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvs_ooo_if.sv
// rvs_ooo_if: dispatch / CDB / issue bundle for the out-of-order reservation station.
// Optional perf counter signals are present when RVS_OOO_PERF_CNT_EN is defined.
interface rvs_ooo_if #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 5,
  parameter int OPC_W = 4,
  parameter int OFS_W = 12,
  parameter int N_CDB = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   flush;
  logic                   dis_req;
  logic                   dis_rdy;
  logic [TAG_W-1:0]       dis_tag;
  logic [OPC_W-1:0]       dis_opc;
  logic [OFS_W-1:0]       dis_offset;
  logic                   dis_src1_vld;
  logic                   dis_src2_vld;
  logic [TAG_W-1:0]       dis_src1_tag;
  logic [TAG_W-1:0]       dis_src2_tag;
  logic [31:0]            dis_src1_wdata;
  logic [31:0]            dis_src2_wdata;
  logic [N_CDB-1:0]       cdb_wr;
  logic [N_CDB*TAG_W-1:0] cdb_tag;
  logic [N_CDB*32-1:0]    cdb_wdata;
  logic                   exu_req;
  logic                   exu_rdy;
  logic [TAG_W-1:0]       exu_tag;
  logic [OPC_W-1:0]       exu_opc;
  logic [OFS_W-1:0]       exu_offset;
  logic [31:0]            exu_src1;
  logic [31:0]            exu_src2;
  logic [CNT_W-1:0]       count;
`ifdef RVS_OOO_PERF_CNT_EN
  logic [31:0]            perf_issue_cnt;
  logic [31:0]            perf_full_stall_cnt;
`endif

  // Upstream / EXU side (drives requests, observes station state)
  modport master (
    output flush, dis_req, dis_opc, dis_offset, dis_src1_vld, dis_src2_vld,
           dis_src1_tag, dis_src2_tag, dis_src1_wdata, dis_src2_wdata,
           cdb_wr, cdb_tag, cdb_wdata, exu_rdy,
    input  dis_rdy, dis_tag, exu_req, exu_tag, exu_opc, exu_offset,
           exu_src1, exu_src2, count
`ifdef RVS_OOO_PERF_CNT_EN
    , input perf_issue_cnt, perf_full_stall_cnt
`endif
  );

  // Station side
  modport slave (
    input  flush, dis_req, dis_opc, dis_offset, dis_src1_vld, dis_src2_vld,
           dis_src1_tag, dis_src2_tag, dis_src1_wdata, dis_src2_wdata,
           cdb_wr, cdb_tag, cdb_wdata, exu_rdy,
    output dis_rdy, dis_tag, exu_req, exu_tag, exu_opc, exu_offset,
           exu_src1, exu_src2, count
`ifdef RVS_OOO_PERF_CNT_EN
    , output perf_issue_cnt, perf_full_stall_cnt
`endif
  );
endinterface

// File: rtl/rvs_ooo.sv
// rvs_ooo: out-of-order reservation station. Entries wake on CDB broadcasts and
// the oldest ready entry issues (age matrix). Entry i owns tag START_ID+i.
// Define RVS_OOO_PERF_CNT_EN to add issue / full-stall performance counters.
module rvs_ooo #(
  parameter int DEPTH    = 8,
  parameter int TAG_W    = 5,
  parameter int OPC_W    = 4,
  parameter int OFS_W    = 12,
  parameter int N_CDB    = 2,
  parameter int START_ID = 1
) (
  input  logic        clk,
  input  logic        rst,
  rvs_ooo_if.slave    bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } snoop_t;

  // Lowest CDB channel carrying tag t wins; tag 0 never matches.
  function automatic snoop_t snoop(input logic [TAG_W-1:0]       t,
                                   input logic [N_CDB-1:0]       wr,
                                   input logic [N_CDB*TAG_W-1:0] tg,
                                   input logic [N_CDB*32-1:0]    dat);
    snoop_t s;
    s = '0;
    for (int c = N_CDB-1; c >= 0; c--) begin
      if (wr[c] && (t != '0) && (tg[c*TAG_W +: TAG_W] == t)) begin
        s.hit  = 1'b1;
        s.data = dat[c*32 +: 32];
      end
    end
    return s;
  endfunction

  logic [DEPTH-1:0]             r_busy, r_vld1, r_vld2;
  logic [DEPTH-1:0][TAG_W-1:0]  r_tag1, r_tag2;
  logic [DEPTH-1:0][31:0]       r_src1, r_src2;
  logic [DEPTH-1:0][OPC_W-1:0]  r_opc;
  logic [DEPTH-1:0][OFS_W-1:0]  r_ofs;
  logic [DEPTH-1:0][DEPTH-1:0]  r_age;   // r_age[i][j]: entry j is older than entry i
  logic [CNT_W-1:0]             r_count;

  logic [IDX_W-1:0] w_free_idx, w_sel_idx;
  logic [DEPTH-1:0] w_ready, w_sel_vec, w_free_vec;
  logic             w_dis_rdy, w_exu_req, w_alloc, w_issue;
  snoop_t           w_s1 [DEPTH];
  snoop_t           w_s2 [DEPTH];
  snoop_t           w_d1, w_d2;
  logic             w_d1_vld, w_d2_vld;
  logic [31:0]      w_d1_dat, w_d2_dat;

  for (genvar g = 0; g < DEPTH; g++) begin : g_snoop
    assign w_s1[g] = snoop(r_tag1[g], bus.cdb_wr, bus.cdb_tag, bus.cdb_wdata);
    assign w_s2[g] = snoop(r_tag2[g], bus.cdb_wr, bus.cdb_tag, bus.cdb_wdata);
  end

  // Dispatched operands also snoop the CDB so a same-cycle broadcast is not lost.
  // A not-valid operand carrying tag 0 has no producer and is taken as ready.
  assign w_d1     = snoop(bus.dis_src1_tag, bus.cdb_wr, bus.cdb_tag, bus.cdb_wdata);
  assign w_d2     = snoop(bus.dis_src2_tag, bus.cdb_wr, bus.cdb_tag, bus.cdb_wdata);
  assign w_d1_vld = bus.dis_src1_vld | (bus.dis_src1_tag == '0) | w_d1.hit;
  assign w_d2_vld = bus.dis_src2_vld | (bus.dis_src2_tag == '0) | w_d2.hit;
  assign w_d1_dat = (!bus.dis_src1_vld && w_d1.hit) ? w_d1.data : bus.dis_src1_wdata;
  assign w_d2_dat = (!bus.dis_src2_vld && w_d2.hit) ? w_d2.data : bus.dis_src2_wdata;

  // Lowest-indexed free entry receives the next dispatch
  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!r_busy[i]) w_free_idx = IDX_W'(i);
  end

  assign w_ready = r_busy & r_vld1 & r_vld2;

  // Oldest ready entry: ready and no other ready entry is older
  always_comb begin
    w_sel_vec = '0;
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_ready[i] && ((w_ready & r_age[i]) == '0)) w_sel_vec[i] = 1'b1;
    for (int i = DEPTH-1; i >= 0; i--)
      if (w_sel_vec[i]) w_sel_idx = IDX_W'(i);
  end

  assign w_dis_rdy  = ~&r_busy;
  assign w_exu_req  = |w_ready;
  assign w_alloc    = bus.dis_req && w_dis_rdy && !bus.flush;
  assign w_issue    = w_exu_req && bus.exu_rdy && !bus.flush;
  assign w_free_vec = w_issue ? w_sel_vec : '0;

  assign bus.dis_rdy    = w_dis_rdy;
  assign bus.dis_tag    = TAG_W'(START_ID) + TAG_W'(w_free_idx);
  assign bus.exu_req    = w_exu_req;
  assign bus.exu_tag    = TAG_W'(START_ID) + TAG_W'(w_sel_idx);
  assign bus.exu_opc    = r_opc[w_sel_idx];
  assign bus.exu_offset = r_ofs[w_sel_idx];
  assign bus.exu_src1   = r_src1[w_sel_idx];
  assign bus.exu_src2   = r_src2[w_sel_idx];
  assign bus.count      = r_count;

  // Entry state: allocate, wake on CDB, free on issue, age tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_vld1 <= '0;
      r_vld2 <= '0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_src1 <= '0;
      r_src2 <= '0;
      r_opc  <= '0;
      r_ofs  <= '0;
      r_age  <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (bus.flush) begin
          r_busy[e] <= 1'b0;
          r_age[e]  <= '0;
        end else if (w_alloc && (w_free_idx == IDX_W'(e))) begin
          r_busy[e] <= 1'b1;
          r_opc[e]  <= bus.dis_opc;
          r_ofs[e]  <= bus.dis_offset;
          r_vld1[e] <= w_d1_vld;
          r_vld2[e] <= w_d2_vld;
          r_tag1[e] <= w_d1_vld ? '0 : bus.dis_src1_tag;
          r_tag2[e] <= w_d2_vld ? '0 : bus.dis_src2_tag;
          r_src1[e] <= w_d1_dat;
          r_src2[e] <= w_d2_dat;
          // every surviving busy entry is older than the newcomer
          r_age[e]  <= r_busy & ~w_free_vec;
        end else begin
          if (w_free_vec[e]) begin
            r_busy[e] <= 1'b0;
            r_age[e]  <= '0;
          end else begin
            r_age[e]  <= r_age[e] & ~w_free_vec;
          end
          if (r_busy[e] && !r_vld1[e] && w_s1[e].hit) begin
            r_vld1[e] <= 1'b1;
            r_tag1[e] <= '0;
            r_src1[e] <= w_s1[e].data;
          end
          if (r_busy[e] && !r_vld2[e] && w_s2[e].hit) begin
            r_vld2[e] <= 1'b1;
            r_tag2[e] <= '0;
            r_src2[e] <= w_s2[e].data;
          end
        end
      end
    end
  end

  // Occupancy: +1 on dispatch, -1 on issue, cleared by flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_count <= '0;
    else if (bus.flush)             r_count <= '0;
    else if (w_alloc && !w_issue)   r_count <= r_count + CNT_W'(1);
    else if (!w_alloc && w_issue)   r_count <= r_count - CNT_W'(1);
  end

`ifdef RVS_OOO_PERF_CNT_EN
  logic [31:0] r_perf_issue, r_perf_stall;

  // Free-running event counters; flush does not touch them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_exu_req && bus.exu_rdy)   r_perf_issue <= r_perf_issue + 32'd1;
      if (bus.dis_req && !w_dis_rdy)  r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign bus.perf_issue_cnt      = r_perf_issue;
  assign bus.perf_full_stall_cnt = r_perf_stall;
`endif
endmodule

// File: tb/tb_rvs_ooo.sv
// tb_rvs_ooo: directed scenarios plus random traffic for rvs_ooo, checked by a
// queue-based age-ordered reference model and an issue scoreboard.
module tb_rvs_ooo;
  localparam int DEPTH    = 8;
  localparam int TAG_W    = 5;
  localparam int OPC_W    = 4;
  localparam int OFS_W    = 12;
  localparam int N_CDB    = 2;
  localparam int START_ID = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rvs_ooo_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OPC_W(OPC_W), .OFS_W(OFS_W), .N_CDB(N_CDB)) bus ();

  rvs_ooo #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OPC_W(OPC_W), .OFS_W(OFS_W),
            .N_CDB(N_CDB), .START_ID(START_ID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int tag; int opc; int ofs;
    bit v1; bit v2; int t1; int t2;
    int unsigned d1; int unsigned d2;
  } ent_t;

  typedef struct {
    int tag; int opc; int ofs; int unsigned s1; int unsigned s2;
  } exp_t;

  ent_t mq[$];      // live ops, oldest first
  exp_t sbq[$];     // expected issues
  int   m_count = 0, m_dis_tag = START_ID;
  bit   m_dis_rdy = 1'b1, m_exu_req = 1'b0;
  int unsigned m_pi = 0, m_ps = 0, c_pi = 0, c_ps = 0;
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit tag_busy(input int t);
    foreach (mq[i]) if (mq[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit cdb_hit(input int t, output int unsigned d);
    d = 0;
    if (t == 0) return 1'b0;
    for (int c = 0; c < N_CDB; c++)
      if (bus.cdb_wr[c] && int'(bus.cdb_tag[c*TAG_W +: TAG_W]) == t) begin
        d = bus.cdb_wdata[c*32 +: 32];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  // One cycle of the reference model: predict outputs from current contents,
  // then apply this cycle's inputs.
  task automatic model_step();
    int sel;
    exp_t x;
    ent_t n;
    int unsigned d;
    if (!rst) begin
      mq.delete();
      m_count = 0; m_dis_rdy = 1'b1; m_dis_tag = START_ID; m_exu_req = 1'b0;
      m_pi = 0; m_ps = 0; c_pi = 0; c_ps = 0;
      return;
    end
    m_count   = mq.size();
    m_dis_rdy = (mq.size() < DEPTH);
    m_dis_tag = START_ID;
    for (int t = START_ID+DEPTH-1; t >= START_ID; t--) if (!tag_busy(t)) m_dis_tag = t;
    sel = -1;
    for (int i = 0; i < mq.size(); i++) if (sel < 0 && mq[i].v1 && mq[i].v2) sel = i;
    m_exu_req = (sel >= 0);
    c_pi = m_pi; c_ps = m_ps;
    if (m_exu_req && bus.exu_rdy)    m_pi++;
    if (bus.dis_req && !m_dis_rdy)   m_ps++;
    if (bus.flush) begin mq.delete(); return; end
    if (m_exu_req && bus.exu_rdy) begin
      x.tag = mq[sel].tag; x.opc = mq[sel].opc; x.ofs = mq[sel].ofs;
      x.s1 = mq[sel].d1;   x.s2 = mq[sel].d2;
      sbq.push_back(x);
      mq.delete(sel);
    end
    for (int i = 0; i < mq.size(); i++) begin
      n = mq[i];
      if (!n.v1 && cdb_hit(n.t1, d)) begin n.v1 = 1'b1; n.t1 = 0; n.d1 = d; end
      if (!n.v2 && cdb_hit(n.t2, d)) begin n.v2 = 1'b1; n.t2 = 0; n.d2 = d; end
      mq[i] = n;
    end
    if (bus.dis_req && m_dis_rdy) begin
      n.tag = m_dis_tag; n.opc = int'(bus.dis_opc); n.ofs = int'(bus.dis_offset);
      n.v1 = bus.dis_src1_vld; n.t1 = n.v1 ? 0 : int'(bus.dis_src1_tag); n.d1 = bus.dis_src1_wdata;
      n.v2 = bus.dis_src2_vld; n.t2 = n.v2 ? 0 : int'(bus.dis_src2_tag); n.d2 = bus.dis_src2_wdata;
      if (!n.v1 && cdb_hit(n.t1, d)) begin n.v1 = 1'b1; n.t1 = 0; n.d1 = d; end
      if (!n.v2 && cdb_hit(n.t2, d)) begin n.v2 = 1'b1; n.t2 = 0; n.d2 = d; end
      mq.push_back(n);
    end
  endtask

  // Model runs mid-cycle, after inputs settle and before the monitor samples
  initial forever begin
    @(posedge clk);
    #4;
    model_step();
  end

  // Monitor: compare status every cycle, pop the scoreboard on each handshake
  initial forever begin
    exp_t e;
    @(negedge clk);
    chk("count",   64'(bus.count),   64'(m_count));
    chk("dis_rdy", 64'(bus.dis_rdy), 64'(m_dis_rdy));
    chk("exu_req", 64'(bus.exu_req), 64'(m_exu_req));
    if (m_dis_rdy) chk("dis_tag", 64'(bus.dis_tag), 64'(m_dis_tag));
`ifdef RVS_OOO_PERF_CNT_EN
    chk("perf_issue", 64'(bus.perf_issue_cnt),      64'(c_pi));
    chk("perf_stall", 64'(bus.perf_full_stall_cnt), 64'(c_ps));
`endif
    if (rst && bus.exu_req && bus.exu_rdy && !bus.flush) begin
      if (sbq.size() == 0) begin
        chk("issue_unexpected", 64'(bus.exu_tag), 64'hFFFF);
      end else begin
        e = sbq.pop_front();
        chk("exu_tag",    64'(bus.exu_tag),    64'(e.tag));
        chk("exu_opc",    64'(bus.exu_opc),    64'(e.opc));
        chk("exu_offset", 64'(bus.exu_offset), 64'(e.ofs));
        chk("exu_src1",   64'(bus.exu_src1),   64'(e.s1));
        chk("exu_src2",   64'(bus.exu_src2),   64'(e.s2));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
    bus.dis_req = 1'b0;
    bus.cdb_wr  = '0;
    bus.flush   = 1'b0;
  endtask

  task automatic dispatch(input int opc, input int ofs,
                          input bit v1, input int t1, input int unsigned d1,
                          input bit v2, input int t2, input int unsigned d2);
    bus.dis_req        = 1'b1;
    bus.dis_opc        = OPC_W'(opc);
    bus.dis_offset     = OFS_W'(ofs);
    bus.dis_src1_vld   = v1;
    bus.dis_src1_tag   = TAG_W'(t1);
    bus.dis_src1_wdata = d1;
    bus.dis_src2_vld   = v2;
    bus.dis_src2_tag   = TAG_W'(t2);
    bus.dis_src2_wdata = d2;
  endtask

  task automatic cdb(input int c, input int tag, input int unsigned data);
    bus.cdb_wr[c]                  = 1'b1;
    bus.cdb_tag[c*TAG_W +: TAG_W]  = TAG_W'(tag);
    bus.cdb_wdata[c*32 +: 32]      = data;
  endtask

  task automatic rnd_cycle();
    bit v;
    if ($urandom_range(0, 99) < 60) begin
      v = 1'($urandom_range(0, 1));
      dispatch($urandom_range(0, 15), $urandom_range(0, 4095),
               v, v ? 0 : $urandom_range(1, 12), $urandom, 1'b1, 0, $urandom);
      bus.dis_src2_vld = 1'($urandom_range(0, 1));
      if (!bus.dis_src2_vld) bus.dis_src2_tag = TAG_W'($urandom_range(1, 12));
    end
    for (int c = 0; c < N_CDB; c++)
      if ($urandom_range(0, 99) < 30) cdb(c, $urandom_range(1, 12), $urandom);
    bus.exu_rdy = ($urandom_range(0, 99) < 70);
    bus.flush   = ($urandom_range(0, 49) == 0);
    step();
  endtask

  initial begin
    bus.flush = 1'b0; bus.dis_req = 1'b0; bus.exu_rdy = 1'b0;
    bus.dis_opc = '0; bus.dis_offset = '0;
    bus.dis_src1_vld = 1'b0; bus.dis_src2_vld = 1'b0;
    bus.dis_src1_tag = '0; bus.dis_src2_tag = '0;
    bus.dis_src1_wdata = '0; bus.dis_src2_wdata = '0;
    bus.cdb_wr = '0; bus.cdb_tag = '0; bus.cdb_wdata = '0;
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();

    // basic: both operands valid, issues next cycle
    bus.exu_rdy = 1'b1;
    dispatch(3, 0, 1'b1, 0, 32'h10, 1'b1, 0, 32'h20);
    step(); step(); step();

    // A waits on tag 9, B ready: B goes first, A after the broadcast
    dispatch(1, 1, 1'b0, 9, 0, 1'b1, 0, 32'hA2);
    step();
    dispatch(2, 2, 1'b1, 0, 32'hB1, 1'b1, 0, 32'hB2);
    step(); step(); step();
    cdb(1, 9, 32'hDEAD);
    step(); step(); step();

    // operand captured from the CDB in the dispatch cycle
    dispatch(4, 3, 1'b1, 0, 32'h1, 1'b0, 7, 0);
    cdb(0, 7, 32'h55);
    step(); step(); step();

    // fill to full, then stalled requests, then drain
    bus.exu_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(i, i, 1'b1, 0, 32'h100 + i, 1'b1, 0, 32'h200 + i);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      dispatch(15, 99, 1'b1, 0, 32'hBAD, 1'b1, 0, 32'hBAD);
      step();
    end
    bus.exu_rdy = 1'b1;
    repeat (DEPTH + 2) step();

    // recycled slots: dispatch order tag3, tag1, tag2 must be issue order
    bus.exu_rdy = 1'b0;
    dispatch(5, 0, 1'b0, 21, 0, 1'b1, 0, 32'h51); step();
    dispatch(6, 0, 1'b0, 22, 0, 1'b1, 0, 32'h62); step();
    dispatch(7, 0, 1'b0, 23, 0, 1'b1, 0, 32'h73); step();
    cdb(0, 21, 32'h2121); cdb(1, 22, 32'h2222); step();
    bus.exu_rdy = 1'b1;
    step(); step();
    bus.exu_rdy = 1'b0;
    dispatch(8, 0, 1'b1, 0, 32'h81, 1'b1, 0, 32'h82); step();
    dispatch(9, 0, 1'b1, 0, 32'h91, 1'b1, 0, 32'h92); step();
    cdb(0, 23, 32'h2323); step();
    bus.exu_rdy = 1'b1;
    repeat (4) step();

    // flush with 5 busy and a simultaneous dispatch
    bus.exu_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dispatch(10, i, 1'b0, 30, 0, 1'b1, 0, 32'hF0 + i);
      step();
    end
    dispatch(11, 0, 1'b1, 0, 32'h1, 1'b1, 0, 32'h2);
    bus.flush = 1'b1;
    step(); step();

    // random traffic with an asynchronous reset in the middle
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
      end
      rnd_cycle();
    end

    bus.exu_rdy = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
